// File: rtl/ten_bt_pkg.sv
// Shared 10BASE-T definitions: link states, receive line states and the
// cycle constants common to the transmit and receive sides.
package ten_bt_pkg;

    typedef enum logic [1:0] {
        LINK_FAIL  = 2'd0,
        LINK_CHECK = 2'd1,
        LINK_PASS  = 2'd2
    } link_state_t;

    localparam logic [1:0] LINE_IDLE = 2'd0;
    localparam logic [1:0] LINE_HI   = 2'd1;
    localparam logic [1:0] LINE_LO   = 2'd2;

    localparam int unsigned NLP_PERIOD = 32'd1 << 18;
    localparam int unsigned CLK_HZ     = 20_000_000;

    // Both legs high or both low is not a valid differential level.
    function automatic logic [1:0] decode_line(input logic p, input logic n);
        if (p && !n) return LINE_HI;
        if (!p && n) return LINE_LO;
        return LINE_IDLE;
    endfunction

endpackage

// File: rtl/ten_bt_pulse_qual.sv
// Synchronises the RX pair, decodes the line level and flags HI pulses whose
// width falls inside [PW_MIN, PW_MAX] when they return to IDLE.
module ten_bt_pulse_qual
    import ten_bt_pkg::*;
#(
    parameter int PW_MIN = 1,
    parameter int PW_MAX = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_p_i,
    input  logic       rx_n_i,
    output logic [1:0] line_o,
    output logic       nlp_seen_o
);

    localparam int            WW    = $clog2(PW_MAX + 2);
    localparam logic [WW-1:0] W_SAT = WW'(PW_MAX + 1);
    localparam logic [WW-1:0] W_MIN = WW'(PW_MIN);
    localparam logic [WW-1:0] W_MAX = WW'(PW_MAX);

    logic [1:0]    sync_p_q;
    logic [1:0]    sync_n_q;
    logic [1:0]    vld_q;
    logic          armed_q, armed_d;
    logic [WW-1:0] width_q, width_d;
    logic          nlp_q, nlp_d;
    logic [1:0]    line_st;

    assign line_st = decode_line(sync_p_q[1], sync_n_q[1]);

    // A pulse already in progress when reset drops must not count, so pulses
    // are only measured once the synchronised line has been seen not HI.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        armed_d = armed_q | (vld_q[1] & (line_st != LINE_HI));
        width_d = '0;
        if (armed_q && (line_st == LINE_HI)) begin
            width_d = (width_q == W_SAT) ? width_q : width_q + WW'(1);
        end
        nlp_d = (line_st == LINE_IDLE) && (width_q >= W_MIN) && (width_q <= W_MAX);
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p_q <= '0;
            sync_n_q <= '0;
            vld_q    <= '0;
            armed_q  <= 1'b0;
            width_q  <= '0;
            nlp_q    <= 1'b0;
        end else begin
            sync_p_q <= {sync_p_q[0], rx_p_i};
            sync_n_q <= {sync_n_q[0], rx_n_i};
            vld_q    <= {vld_q[0], 1'b1};
            armed_q  <= armed_d;
            width_q  <= width_d;
            nlp_q    <= nlp_d;
        end
    end

    assign line_o     = line_st;
    assign nlp_seen_o = nlp_q;

endmodule

// File: rtl/ten_bt_link_rx.sv
// 10BASE-T receive link integrity: NLP interval checking, loss timing,
// carrier sense and the FAIL/CHECK/PASS link state machine.
module ten_bt_link_rx
    import ten_bt_pkg::*;
#(
    parameter int PW_MIN      = 1,
    parameter int PW_MAX      = 4,
    parameter int INT_MIN     = 160000,
    parameter int INT_MAX     = 480000,
    parameter int LOSS_MAX    = 3000000,
    parameter int GOOD_NLP    = 3,
    parameter int CARRIER_WIN = 8,
    parameter int TMR_W       = 22
) (
    input  logic PLL_CLK,
    input  logic RST,
    input  logic RX_P,
    input  logic RX_N,
    output logic LINK_UP,
    output logic NLP_SEEN,
    output logic NLP_ERR,
    output logic CARRIER
);

    localparam int               CW     = $clog2(CARRIER_WIN + 1);
    localparam int               GW     = $clog2(GOOD_NLP + 1);
    localparam logic [TMR_W-1:0] T_SAT  = '1;
    localparam logic [TMR_W-1:0] T_MIN  = TMR_W'(INT_MIN);
    localparam logic [TMR_W-1:0] T_MAX  = TMR_W'(INT_MAX);
    localparam logic [TMR_W-1:0] T_LOSS = TMR_W'(LOSS_MAX);
    localparam logic [GW-1:0]    G_LAST = GW'(GOOD_NLP - 1);

    logic [1:0]       line_st, prev_line_q;
    logic             nlp_seen;
    logic [TMR_W-1:0] int_q, int_d;
    logic [TMR_W-1:0] loss_q, loss_d;
    logic [CW-1:0]    car_q, car_d;
    logic [GW-1:0]    good_q, good_d;
    link_state_t      state_q, state_d;
    logic             in_window, loss_evt, data_edge;

    ten_bt_pulse_qual #(
        .PW_MIN(PW_MIN),
        .PW_MAX(PW_MAX)
    ) u_pulse_qual (
        .clk_i     (PLL_CLK),
        .rst_i     (RST),
        .rx_p_i    (RX_P),
        .rx_n_i    (RX_N),
        .line_o    (line_st),
        .nlp_seen_o(nlp_seen)
    );

    assign in_window = (int_q >= T_MIN) && (int_q <= T_MAX);
    assign loss_evt  = (loss_q == T_LOSS);
    assign data_edge = ((prev_line_q == LINE_HI) && (line_st == LINE_LO)) ||
                       ((prev_line_q == LINE_LO) && (line_st == LINE_HI));

    always_comb begin
        int_d   = nlp_seen ? '0 : ((int_q == T_SAT) ? int_q : int_q + TMR_W'(1));
        loss_d  = (nlp_seen || CARRIER) ? '0 : (loss_evt ? loss_q : loss_q + TMR_W'(1));
        car_d   = data_edge ? CW'(CARRIER_WIN) : ((car_q != '0) ? car_q - CW'(1) : '0);
        state_d = state_q;
        good_d  = good_q;
        // An NLP in the loss cycle wins: each NLP branch is tested before loss.
        case (state_q)
            LINK_FAIL: begin
                if (nlp_seen) begin
                    state_d = LINK_CHECK;
                    good_d  = GW'(1);
                end
            end
            LINK_CHECK: begin
                if (nlp_seen) begin
                    if (!in_window) begin
                        good_d = GW'(1);
                    end else if (good_q == G_LAST) begin
                        state_d = LINK_PASS;
                        good_d  = GW'(GOOD_NLP);
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end else if (loss_evt) begin
                    state_d = LINK_FAIL;
                    good_d  = '0;
                end
            end
            LINK_PASS: begin
                if (!nlp_seen && loss_evt) begin
                    state_d = LINK_FAIL;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = LINK_FAIL;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PLL_CLK or posedge RST) begin
        if (RST) begin
            prev_line_q <= LINE_IDLE;
            int_q       <= '0;
            loss_q      <= '0;
            car_q       <= '0;
            good_q      <= '0;
            state_q     <= LINK_FAIL;
        end else begin
            prev_line_q <= line_st;
            int_q       <= int_d;
            loss_q      <= loss_d;
            car_q       <= car_d;
            good_q      <= good_d;
            state_q     <= state_d;
        end
    end

    assign LINK_UP  = (state_q == LINK_PASS);
    assign NLP_SEEN = nlp_seen;
    assign NLP_ERR  = nlp_seen & ~in_window;
    assign CARRIER  = (car_q != '0);

endmodule

// File: tb/tb_ten_bt_link_rx.sv
// Self-checking bench for ten_bt_link_rx: every driven pulse queues its expected
// NLP_ERR / LINK_UP outcome, popped when the DUT raises NLP_SEEN.
module tb_ten_bt_link_rx;

    // Protocol intervals shrunk ~2000x so the whole run stays a few thousand cycles.
    localparam int INT_MIN     = 80;
    localparam int INT_MAX     = 240;
    localparam int LOSS_MAX    = 1500;
    localparam int TMR_W       = 12;
    localparam int CARRIER_WIN = 8;
    localparam int PERIOD      = 160;

    logic PLL_CLK = 1'b0;
    logic RST     = 1'b1;
    logic RX_P    = 1'b0;
    logic RX_N    = 1'b0;
    logic LINK_UP, NLP_SEEN, NLP_ERR, CARRIER;

    typedef struct packed {
        logic err;
        logic link;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_mis   = 0;
    int   nlp_cnt = 0;
    int   cyc     = 0;
    int   nlp_cyc = 0;

    ten_bt_link_rx #(
        .INT_MIN    (INT_MIN),
        .INT_MAX    (INT_MAX),
        .LOSS_MAX   (LOSS_MAX),
        .CARRIER_WIN(CARRIER_WIN),
        .TMR_W      (TMR_W)
    ) dut (
        .PLL_CLK (PLL_CLK),
        .RST     (RST),
        .RX_P    (RX_P),
        .RX_N    (RX_N),
        .LINK_UP (LINK_UP),
        .NLP_SEEN(NLP_SEEN),
        .NLP_ERR (NLP_ERR),
        .CARRIER (CARRIER)
    );

    always #5 PLL_CLK = ~PLL_CLK;
    always @(posedge PLL_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PLL_CLK);
    endtask

    // Called at a negedge; the line is HI for exactly w rising edges.
    task automatic drive_hi(input int w);
        RX_P = 1'b1;
        RX_N = 1'b0;
        repeat (w) @(negedge PLL_CLK);
        RX_P = 1'b0;
    endtask

    // Uses w+5 negedges; NLP_SEEN lands 3 edges after the last HI sample.
    task automatic send_pulse(input int w, input logic err, input logic link);
        exp_t e;
        e.err  = err;
        e.link = link;
        sb.push_back(e);
        drive_hi(w);
        idle(5);
        check("nlp_drained", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge PLL_CLK);
            if (NLP_SEEN === 1'b1) begin
                nlp_cnt++;
                nlp_cyc = cyc;
                check("nlp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("nlp_err", NLP_ERR, e.err);
                    @(negedge PLL_CLK);
                    check("link_after_nlp", LINK_UP, e.link);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        int guard;
        int car_low;
        int link_low;
        int last_cyc;

        repeat (5) @(negedge PLL_CLK);
        check("rst_outputs", {LINK_UP, NLP_SEEN, NLP_ERR, CARRIER}, 0);
        RST = 1'b0;
        idle(20);
        check("post_rst_outputs", {LINK_UP, NLP_SEEN, NLP_ERR, CARRIER}, 0);

        // First NLP after reset is ~26 cycles in: out of window, still enters CHECK.
        send_pulse(2, 1'b1, 1'b0);
        idle(PERIOD - 7);
        send_pulse(2, 1'b0, 1'b0);
        idle(PERIOD - 7);
        send_pulse(2, 1'b0, 1'b1);

        // Loss timer is 0 the cycle after NLP_SEEN, hits LOSS_MAX LOSS_MAX+1
        // cycles later, and LINK_UP drops the cycle after that.
        guard = 0;
        while (LINK_UP === 1'b1 && guard < LOSS_MAX + 100) begin
            @(negedge PLL_CLK);
            guard++;
        end
        check("loss_latency", cyc - nlp_cyc, LOSS_MAX + 2);

        idle(10);
        n0 = nlp_cnt;
        drive_hi(5);
        idle(10);
        RX_P = 1'b1;
        #2;
        RX_P = 1'b0;
        idle(10);
        check("width_rejected", nlp_cnt, n0);
        check("fail_held", LINK_UP, 0);

        // 4-wide then 2-wide starts 162 apart: NLPs 160 apart, timer 159.
        send_pulse(4, 1'b1, 1'b0);
        idle(162 - 9);
        send_pulse(2, 1'b0, 1'b0);
        idle(50 - 7);
        send_pulse(2, 1'b1, 1'b0);
        idle(PERIOD - 7);
        send_pulse(2, 1'b0, 1'b0);
        idle(PERIOD - 7);
        send_pulse(2, 1'b0, 1'b1);

        // NLP lands on the exact loss cycle: out of window but the link holds.
        idle(LOSS_MAX + 1 - 7);
        send_pulse(2, 1'b1, 1'b1);

        idle(20);
        n0       = nlp_cnt;
        car_low  = 0;
        link_low = 0;
        last_cyc = 0;
        for (int i = 0; i < 500; i++) begin
            RX_P = 1'b1;
            RX_N = 1'b0;
            repeat (2) begin
                @(negedge PLL_CLK);
                if (i >= 2) begin
                    car_low  += int'(!CARRIER);
                    link_low += int'(!LINK_UP);
                end
            end
            RX_P     = 1'b0;
            RX_N     = 1'b1;
            last_cyc = cyc;
            repeat (2) begin
                @(negedge PLL_CLK);
                if (i >= 2) begin
                    car_low  += int'(!CARRIER);
                    link_low += int'(!LINK_UP);
                end
            end
        end
        RX_N = 1'b0;
        guard = 0;
        while (CARRIER === 1'b1 && guard < 50) begin
            @(negedge PLL_CLK);
            guard++;
        end
        check("carrier_held", car_low, 0);
        check("link_held_by_carrier", link_low, 0);
        check("no_nlp_in_data", nlp_cnt, n0);
        // 2 sync flops + line compare register, then CARRIER_WIN cycles high.
        check("carrier_drop", cyc - last_cyc, CARRIER_WIN + 3);
        check("link_after_burst", LINK_UP, 1);

        idle(10);
        check("pre_rst_link", LINK_UP, 1);
        n0   = nlp_cnt;
        RX_P = 1'b1;
        RX_N = 1'b0;
        @(posedge PLL_CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_outputs", {LINK_UP, NLP_SEEN, NLP_ERR, CARRIER}, 0);
        @(posedge PLL_CLK);
        #2 RST = 1'b0;
        @(negedge PLL_CLK);
        @(negedge PLL_CLK);
        RX_P = 1'b0;
        idle(20);
        check("cut_pulse_dropped", nlp_cnt, n0);
        check("fail_after_rst", LINK_UP, 0);
        send_pulse(2, 1'b1, 1'b0);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
